fix_field_assembler: RTL
========================

Name: fix_field_assembler

Overview:
Sits directly downstream of the FIX byte parser and consumes its per-byte data, tag-strobe and value-strobe outputs. It assembles each "tag=value<SOH>" field into a single record:
- binary tag number
- packed value bytes
- value length
- error flags

Each record is presented on a valid/ready output, one field per handshake, to the message-decode stage.

Parameters:
TAG_W, 20, width of binary tag number (FIX tags up to 6 digits)
VAL_BYTES, 16, maximum stored value bytes; extra bytes are dropped
LEN_W, $clog2(VAL_BYTES+1), width of value length

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
data_i  in  8  byte from parser, qualified by strobes
tag_s_i  in  1  data_i is a tag byte this cycle
value_s_i  in  1  data_i is a value byte this cycle
field_valid_o  out  1  assembled field available
field_ready_i  in  1  downstream accepts field
tag_o  out  TAG_W  binary tag number
val_o  out  VAL_BYTES*8  value bytes; byte k at [8k+7:8k], unused bytes zero
len_o  out  LEN_W  stored value byte count
tag_err_o  out  1  non-digit tag byte or tag overflow
trunc_o  out  1  value longer than VAL_BYTES
ovf_o  out  1  sticky: field dropped because output register was full
sum_o  out  8  field checksum (see Optional Feature)

Behaviour:
- Reset (async assert, sync release): state S_IDLE; all outputs 0; accumulators cleared.
- "Gap" cycle: tag_s_i=0 and value_s_i=0.
- Both strobes high: value_s_i ignored, treated as tag byte.
- S_IDLE:
  - tag_s_i=1 → S_TAG; start a new tag with this byte.
  - Otherwise stay in S_IDLE.
- S_TAG:
  - tag_s_i=1 → accumulate the byte.
  - Gap → S_VAL. This is the '=' cycle.
  - value_s_i without a preceding gap → treated as gap plus value byte.
- Tag accumulation:
  - tag = tag*10 + (byte-0x30).
  - Byte outside 0x30..0x39 sets tag_err.
  - Result exceeding 2^TAG_W-1 sets tag_err; tag saturates at all-ones.
- S_VAL:
  - value_s_i=1 → store the byte at index len if len<VAL_BYTES, else set trunc; len saturates at VAL_BYTES.
  - Gap (SOH) → field complete → S_IDLE.
  - tag_s_i=1 → field complete; this byte starts the next tag → S_TAG.
  - Zero value bytes before the gap is legal: emits len=0.
- Output register is one entry.
  - On field completion with field_valid_o=0 or (field_valid_o & field_ready_i): load tag/val/len/flags; field_valid_o=1 on the next edge. Latency is 1 cycle after the terminating cycle.
  - Completion while field_valid_o=1 and field_ready_i=0: new field dropped, ovf_o set (sticky until reset). Held outputs stay stable.
  - field_valid_o falls after an accepted handshake unless reloaded in the same cycle.
- Accumulators clear on each new tag start; back-to-back fields with one-cycle gaps sustain full rate.
- Reset mid-field: partial field discarded; no record emitted.

Optional Feature:
FIX_FIELD_CHECKSUM_EN.
- Defined: sum_o = mod-256 sum of all tag bytes + 0x3D + all received value bytes (including truncated ones) + 0x01, registered with the field. This is the field's contribution to FIX tag 10.
- Undefined: sum_o tied to 0, and no adder logic is built.

Decomposition:
- Package fix_pkg:
  - ASCII constants SOH_C=8'h01, SEP_C=8'h3D, DIG0_C=8'h30, DIG9_C=8'h39.
  - State enum {S_IDLE,S_TAG,S_VAL}.
  - Field record struct: tag, val, len, tag_err, trunc, sum.
- Sub-module fix_tag_decoder: digit check, multiply-by-10 accumulate, saturation and overflow flag.

Test Plan:
- "35=D<SOH>": tag '3','5', gap, 'D', gap, ready=1 → tag_o=35, len_o=1, val_o[7:0]=0x44, flags 0; sum_o=0xEA with macro, 0 without.
- Backpressure: ready=0, two fields "8=FIX.4.2" then "9=12" → first held stable; second dropped; ovf_o=1. Then ready=1 → field tag 8, len 7.
- 20-byte value on tag 58 → len_o=16, val_o = first 16 bytes, trunc_o=1.
- Tag "1A" → tag_err_o=1. Tag "9999999" → tag_err_o=1, tag_o=0xFFFFF.
- Empty value "11=<SOH>" → tag_o=11, len_o=0. Followed directly by tag_s byte with no gap → next field assembles correctly.
- rst_n pulsed low after tag byte '4' → outputs 0 immediately. Following "49=X<SOH>" → single field tag 49, len 1.

Source files
------------

// File: rtl/fix_pkg.sv
// ============================================================================
// Module   : fix_pkg
// Purpose  : Shared ASCII constants, FSM states and field record for the
//            FIX field assembler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fix_pkg;

    localparam logic [7:0] SOH_C  = 8'h01;
    localparam logic [7:0] SEP_C  = 8'h3D;
    localparam logic [7:0] DIG0_C = 8'h30;
    localparam logic [7:0] DIG9_C = 8'h39;

    localparam int TAG_W_C     = 20;
    localparam int VAL_BYTES_C = 16;
    localparam int LEN_W_C     = $clog2(VAL_BYTES_C + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TAG  = 2'd1,
        S_VAL  = 2'd2
    } fix_state_e;

    typedef struct packed {
        logic [TAG_W_C-1:0]       tag;
        logic [VAL_BYTES_C*8-1:0] val;
        logic [LEN_W_C-1:0]       len;
        logic                     tag_err;
        logic                     trunc;
        logic [7:0]               sum;
    } fix_rec_t;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= DIG0_C) && (b <= DIG9_C);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fix_tag_decoder.sv
// ============================================================================
// Module   : fix_tag_decoder
// Purpose  : Combinational ASCII-decimal tag accumulator with digit check,
//            overflow detection and saturation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fix_tag_decoder
    import fix_pkg::*;
#(
    parameter int TAG_W = TAG_W_C
) (
    input  logic             start_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic             err_i,
    input  logic [7:0]       byte_i,
    output logic [TAG_W-1:0] tag_o,
    output logic             err_o
);

    localparam int PROD_W = TAG_W + 4;

    logic [TAG_W-1:0]  w_base;
    logic              w_base_err;
    logic [PROD_W-1:0] w_prod;
    logic [PROD_W-1:0] w_base_ext;

    always_comb begin
        w_base     = start_i ? '0 : tag_i;
        w_base_err = start_i ? 1'b0 : err_i;
        w_base_ext = {4'b0000, w_base};
        // Low nibble of an ASCII digit is its value; x10 = x8 + x2.
        w_prod     = (w_base_ext << 3) + (w_base_ext << 1)
                   + {{(PROD_W-4){1'b0}}, byte_i[3:0]};
        tag_o      = w_base;
        err_o      = w_base_err;
        if (!is_digit(byte_i)) begin
            err_o = 1'b1;
        end else if (w_prod > {4'b0000, {TAG_W{1'b1}}}) begin
            tag_o = '1;
            err_o = 1'b1;
        end else begin
            tag_o = w_prod[TAG_W-1:0];
        end
    end

endmodule

`default_nettype wire

// File: rtl/fix_field_assembler.sv
// ============================================================================
// Module   : fix_field_assembler
// Purpose  : Assembles parser byte/strobe stream into tag/value field records
//            on a one-entry valid/ready output. Optional checksum: define
//            FIX_FIELD_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fix_field_assembler
    import fix_pkg::*;
#(
    parameter int TAG_W     = TAG_W_C,
    parameter int VAL_BYTES = VAL_BYTES_C,
    parameter int LEN_W     = $clog2(VAL_BYTES + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             data_i,
    input  logic                   tag_s_i,
    input  logic                   value_s_i,
    output logic                   field_valid_o,
    input  logic                   field_ready_i,
    output logic [TAG_W-1:0]       tag_o,
    output logic [VAL_BYTES*8-1:0] val_o,
    output logic [LEN_W-1:0]       len_o,
    output logic                   tag_err_o,
    output logic                   trunc_o,
    output logic                   ovf_o,
    output logic [7:0]             sum_o
);

    fix_state_e             state_q;
    logic [TAG_W-1:0]       tag_acc_q;
    logic                   tag_err_q;
    logic [VAL_BYTES*8-1:0] val_q;
    logic [LEN_W-1:0]       len_q;
    logic                   trunc_q;
    fix_rec_t               rec_q;
    logic                   field_valid_q;
    logic                   ovf_q;

    logic [TAG_W-1:0]       tag_d;
    logic                   tag_err_d;
    logic [VAL_BYTES*8-1:0] val_d;
    logic [LEN_W-1:0]       len_d;
    logic                   trunc_d;
    logic [7:0]             sum_d;
    fix_rec_t               rec_d;

    logic w_is_tag;
    logic w_is_val;
    logic w_start;
    logic w_store;
    logic w_complete;

    assign w_is_tag   = tag_s_i;
    assign w_is_val   = value_s_i & ~tag_s_i;
    assign w_start    = w_is_tag & (state_q != S_TAG);
    assign w_store    = w_is_val & (state_q != S_IDLE);
    assign w_complete = (state_q == S_VAL) & ~w_is_val;

    fix_tag_decoder #(
        .TAG_W (TAG_W)
    ) u_tag_dec (
        .start_i (state_q != S_TAG),
        .tag_i   (tag_acc_q),
        .err_i   (tag_err_q),
        .byte_i  (data_i),
        .tag_o   (tag_d),
        .err_o   (tag_err_d)
    );

    always_comb begin
        val_d   = val_q;
        len_d   = len_q;
        trunc_d = trunc_q;
        if (len_q < LEN_W'(VAL_BYTES)) begin
            for (int k = 0; k < VAL_BYTES; k++) begin
                if (LEN_W'(k) == len_q) begin
                    val_d[8*k +: 8] = data_i;
                end
            end
            len_d = len_q + LEN_W'(1);
        end else begin
            trunc_d = 1'b1;
        end
    end

`ifdef FIX_FIELD_CHECKSUM_EN
    logic [7:0] sum_q;
    logic [7:0] w_sum_next;

    // The '=' is implied by leaving S_TAG; the SOH is implied at completion.
    always_comb begin
        w_sum_next = sum_q;
        if (w_is_tag) begin
            w_sum_next = (state_q == S_TAG) ? sum_q + data_i : data_i;
        end else if (state_q == S_TAG) begin
            w_sum_next = sum_q + SEP_C + (w_is_val ? data_i : 8'h00);
        end else if (w_store) begin
            w_sum_next = sum_q + data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= 8'h00;
        end else begin
            sum_q <= w_sum_next;
        end
    end

    assign sum_d = sum_q + SOH_C;
`else
    assign sum_d = 8'h00;
`endif

    always_comb begin
        rec_d         = '0;
        rec_d.tag     = tag_acc_q;
        rec_d.val     = val_q;
        rec_d.len     = len_q;
        rec_d.tag_err = tag_err_q;
        rec_d.trunc   = trunc_q;
        rec_d.sum     = sum_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            tag_acc_q     <= '0;
            tag_err_q     <= 1'b0;
            val_q         <= '0;
            len_q         <= '0;
            trunc_q       <= 1'b0;
            rec_q         <= '0;
            field_valid_q <= 1'b0;
            ovf_q         <= 1'b0;
        end else begin
            if (w_is_tag) begin
                tag_acc_q <= tag_d;
                tag_err_q <= tag_err_d;
            end
            if (w_start) begin
                val_q   <= '0;
                len_q   <= '0;
                trunc_q <= 1'b0;
            end else if (w_store) begin
                val_q   <= val_d;
                len_q   <= len_d;
                trunc_q <= trunc_d;
            end

            case (state_q)
                S_IDLE: if (w_is_tag) state_q <= S_TAG;
                S_TAG:  if (!w_is_tag) state_q <= S_VAL;
                S_VAL: begin
                    if (w_is_tag) begin
                        state_q <= S_TAG;
                    end else if (!w_is_val) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            // A full, stalled output register drops the new field.
            if (w_complete && (!field_valid_q || field_ready_i)) begin
                rec_q         <= rec_d;
                field_valid_q <= 1'b1;
            end else begin
                if (w_complete) begin
                    ovf_q <= 1'b1;
                end
                if (field_valid_q && field_ready_i) begin
                    field_valid_q <= 1'b0;
                end
            end
        end
    end

    assign field_valid_o = field_valid_q;
    assign tag_o         = rec_q.tag;
    assign val_o         = rec_q.val;
    assign len_o         = rec_q.len;
    assign tag_err_o     = rec_q.tag_err;
    assign trunc_o       = rec_q.trunc;
    assign ovf_o         = ovf_q;
    assign sum_o         = rec_q.sum;

endmodule

`default_nettype wire
